// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the sequential restoring divider.
//   state_t        : FSM encoding (IDLE / CALC / DONE)
//   DEF_DIVIDEND_W : default dividend / quotient width
//   DEF_DIVISOR_W  : default divisor / remainder width
//   cnt_width()    : width of the iteration counter for a given dividend width
//   DBZ_QUOT_BIT   : fill bit of the divide-by-zero quotient (all ones)
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DEF_DIVIDEND_W = 16;
  localparam int DEF_DIVISOR_W  = 8;

  // Divide-by-zero quotient is this bit replicated across the quotient.
  localparam logic DBZ_QUOT_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter runs 0..w-1, so $clog2(w) bits are enough.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
// Ports:
//   i_prem    [DIVISOR_W-1:0] partial remainder entering the step (< divisor)
//   i_bit                     next dividend bit (MSB first)
//   i_divisor [DIVISOR_W-1:0] divisor
//   o_prem    [DIVISOR_W-1:0] partial remainder leaving the step
//   o_qbit                    quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W-1:0] i_prem,
  input  logic                 i_bit,
  input  logic [DIVISOR_W-1:0] i_divisor,
  output logic [DIVISOR_W-1:0] o_prem,
  output logic                 o_qbit
);

  logic [DIVISOR_W:0]   w_shift;
  logic [DIVISOR_W-1:0] w_diff;

  // Incoming remainder is below the divisor, so the shifted value needs
  // exactly one extra bit.
  assign w_shift = {i_prem, i_bit};
  assign o_qbit  = (w_shift >= {1'b0, i_divisor});

  // When subtraction happens the true difference is below the divisor, so the
  // carry-out bit is always zero and a DIVISOR_W-bit subtract is exact.
  assign w_diff  = w_shift[DIVISOR_W-1:0] - i_divisor;
  assign o_prem  = o_qbit ? w_diff : w_shift[DIVISOR_W-1:0];

endmodule

// File: rtl/div_16x8_seq.sv
// -----------------------------------------------------------------------------
// div_16x8_seq
// Sequential radix-2 restoring divider, one quotient bit per clock, with
// valid/ready handshakes on operands and result.
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   in_valid / in_ready        operand handshake (accepted only in IDLE)
//   DIVIDEND [DIVIDEND_W-1:0]  unsigned dividend
//   DIVISOR  [DIVISOR_W-1:0]   unsigned divisor
//   out_valid / out_ready      result handshake (result held under backpressure)
//   QUOT     [DIVIDEND_W-1:0]  quotient (all ones on divide by zero)
//   REM      [DIVISOR_W-1:0]   remainder (low dividend bits on divide by zero)
//   DIV_BY_ZERO                result came from a zero divisor
//   CHECK_ERR                  only with DIV_SELFCHECK_EN: result fails the
//                              QUOT*DIVISOR+REM == DIVIDEND / REM < DIVISOR test
// Optional feature macro: DIV_SELFCHECK_EN
// -----------------------------------------------------------------------------
module div_16x8_seq
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] DIVIDEND,
  input  logic [DIVISOR_W-1:0]  DIVISOR,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] QUOT,
  output logic [DIVISOR_W-1:0]  REM,
`ifdef DIV_SELFCHECK_EN
  output logic                  CHECK_ERR,
`endif
  output logic                  DIV_BY_ZERO
);

  localparam int CNT_W = cnt_width(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_work;     // dividend shifts out the top, quotient in the bottom
  logic [DIVISOR_W-1:0]  r_prem;
  logic [DIVISOR_W-1:0]  r_divisor;
  logic [DIVIDEND_W-1:0] r_quot;
  logic [DIVISOR_W-1:0]  r_rem;
  logic                  r_dbz;

  logic [DIVISOR_W-1:0]  w_prem_next;
  logic                  w_qbit;
  logic                  w_last;
  logic                  w_div_zero;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .i_prem    (r_prem),
    .i_bit     (r_work[DIVIDEND_W-1]),
    .i_divisor (r_divisor),
    .o_prem    (w_prem_next),
    .o_qbit    (w_qbit)
  );

  assign w_last     = (r_cnt == CNT_LAST);
  assign w_div_zero = (DIVISOR == '0);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first keeps every path driven, so no latch
  // is inferred when a case branch leaves the signal untouched.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_state_next = w_div_zero ? DONE : CALC;
      CALC: if (w_last)   w_state_next = DONE;
      DONE: if (out_ready) w_state_next = IDLE;
      default:            w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_work    <= '0;
      r_prem    <= '0;
      r_divisor <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dbz     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work    <= DIVIDEND;
            r_prem    <= '0;
            r_divisor <= DIVISOR;
            r_cnt     <= '0;
            r_dbz     <= w_div_zero;
            // A zero divisor skips CALC, so the result is produced right here.
            if (w_div_zero) begin
              r_quot <= {DIVIDEND_W{DBZ_QUOT_BIT}};
              r_rem  <= DIVIDEND[DIVISOR_W-1:0];
            end
          end
        end
        CALC: begin
          r_work <= {r_work[DIVIDEND_W-2:0], w_qbit};
          r_prem <= w_prem_next;
          if (w_last) begin
            r_cnt  <= '0;
            r_quot <= {r_work[DIVIDEND_W-2:0], w_qbit};
            r_rem  <= w_prem_next;
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
          end
        end
        default: ;  // DONE: result registers hold under backpressure
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign QUOT        = r_quot;
  assign REM         = r_rem;
  assign DIV_BY_ZERO = r_dbz;

`ifdef DIV_SELFCHECK_EN
  // ---------------------------------------------------------------------------
  // Result self-check: exact reconstruction of the dividend from the result.
  // ---------------------------------------------------------------------------
  localparam int PW = DIVIDEND_W + DIVISOR_W;

  logic [DIVIDEND_W-1:0] r_dividend;
  logic [PW-1:0]         w_recon;

  // r_work is consumed by the shift, so the original dividend is kept aside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_dividend <= '0;
    else if (r_state == IDLE && in_valid) r_dividend <= DIVIDEND;
  end

  assign w_recon   = PW'(r_quot) * PW'(r_divisor) + PW'(r_rem);
  assign CHECK_ERR = out_valid && !r_dbz &&
                     ((w_recon != PW'(r_dividend)) || (r_rem >= r_divisor));
`endif

endmodule

// File: tb/tb_div_16x8_seq.sv
// -----------------------------------------------------------------------------
// tb_div_16x8_seq
// Self-checking bench for div_16x8_seq: directed cases, backpressure, reset
// during CALC and a randomized run against a plain arithmetic reference.
// Honours DIV_SELFCHECK_EN (connects and checks CHECK_ERR).
// -----------------------------------------------------------------------------
module tb_div_16x8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quot;
  logic [7:0]  rem;
  logic        dbz;
`ifdef DIV_SELFCHECK_EN
  logic        check_err;
`endif

  int total = 0;
  int bad   = 0;

  div_16x8_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .DIVIDEND    (dividend),
    .DIVISOR     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .QUOT        (quot),
    .REM         (rem),
`ifdef DIV_SELFCHECK_EN
    .CHECK_ERR   (check_err),
`endif
    .DIV_BY_ZERO (dbz)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge; all sampling and driving is done here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] q, output logic [7:0] r);
    if (b == 8'd0) begin
      q = 16'hFFFF;
      r = a[7:0];
    end else begin
      q = a / 16'(b);
      r = 8'(a % 16'(b));
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid appears.
  task automatic wait_result(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [7:0] b, input int n);
    logic [15:0] eq;
    logic [7:0]  er;
    ref_div(a, b, eq, er);
    check({tag, "_latency"}, 32'(n), (b == 8'd0) ? 32'd0 : 32'd16);
    check({tag, "_valid"},   32'(out_valid), 32'd1);
    check({tag, "_quot"},    32'(quot), 32'(eq));
    check({tag, "_rem"},     32'(rem), 32'(er));
    check({tag, "_dbz"},     32'(dbz), (b == 8'd0) ? 32'd1 : 32'd0);
`ifdef DIV_SELFCHECK_EN
    check({tag, "_chkerr"},  32'(check_err), 32'd0);
`endif
  endtask

  // Full transaction with out_ready high: accept, wait, check, hand off.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b);
    int n;
    start_op(a, b);
    wait_result(n);
    check_result(tag, a, b, n);
    tick();
  endtask

  initial begin
    int          n;
    logic [15:0] ra;
    logic [7:0]  rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quot",      32'(quot),      32'd0);
    check("rst_rem",       32'(rem),       32'd0);
    check("rst_dbz",       32'(dbz),       32'd0);
    rst = 1'b0;
    tick();

    // 100 / 7, then in_ready must be back at T+18
    run_op("d100_7", 16'd100, 8'd7);
    check("d100_7_ready_back", 32'(in_ready), 32'd1);
    check("d100_7_valid_gone", 32'(out_valid), 32'd0);

    run_op("d65535_1", 16'd65535, 8'd1);
    run_op("d300_255", 16'd300,   8'd255);
    run_op("d5_200",   16'd5,     8'd200);
    run_op("d0_13",    16'd0,     8'd13);
    run_op("dz1234",   16'h1234,  8'd0);
    run_op("d9_3",     16'd9,     8'd3);

    // Backpressure: result held, in_ready low, stray in_valid ignored
    out_ready = 1'b0;
    start_op(16'd1000, 8'd9);
    wait_result(n);
    check_result("stall", 16'd1000, 8'd9, n);
    dividend = 16'd7;
    divisor  = 8'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_quot",  32'(quot),      32'd111);
      check("stall_rem",   32'(rem),       32'd1);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_ready", 32'(in_ready),  32'd0);
      check("stall_dbz",   32'(dbz),       32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("stall_release_ready", 32'(in_ready),  32'd1);
    check("stall_release_valid", 32'(out_valid), 32'd0);
    tick();
    check("stall_nothing_queued", 32'(out_valid), 32'd0);

    // Reset asserted at T+8 during CALC: immediate return to reset values
    start_op(16'd1000, 8'd7);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    #1;
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_quot",      32'(quot),      32'd0);
    check("midrst_rem",       32'(rem),       32'd0);
    check("midrst_dbz",       32'(dbz),       32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_op("d50_5", 16'd50, 8'd5);

    // Randomized back-to-back run, with some zero divisors and small dividends
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 16'($urandom_range(0, 300));
      rb = 8'($urandom);
      if ($urandom_range(0, 15) == 0) rb = 8'd0;
      run_op("rnd", ra, rb);
    end

`ifdef DIV_SELFCHECK_EN
    // Corrupt the held quotient and expect the self-check to flag it
    out_ready = 1'b0;
    start_op(16'd1000, 8'd9);
    wait_result(n);
    check("corrupt_pre_chkerr", 32'(check_err), 32'd0);
    force dut.r_quot = 16'd112;
    #1;
    check("corrupt_chkerr", 32'(check_err), 32'd1);
    release dut.r_quot;
    out_ready = 1'b1;
    tick();
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
